// File: rtl/tpu_pkg.sv
// Shared TPU definitions: operand width and systolic dimension defaults,
// loader state encoding and the drain-window length helper.
package tpu_pkg;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_DIM     = 8;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} loader_state_t;

  // Skewed columns need 3*DIM-2 shifts to fully drain through the array.
  function automatic int stream_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/mema_loader.sv
// memA upstream sequencer: writes DIM rows (1-cycle handshake-to-WrEn latency),
// then holds en for the drain window; in_ready only in LOAD, abort cancels a pass.
module mema_loader
  import tpu_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int DIM     = DEF_DIM
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIM-1:0][BITS_AB-1:0]   in_row,
  output logic [DIM-1:0][BITS_AB-1:0]   Ain,
  output logic [$clog2(DIM)-1:0]        Arow,
  output logic                          WrEn,
  output logic                          en,
  output logic                          busy,
  output logic                          done
);

  localparam int SC     = stream_cycles(DIM);
  localparam int AROW_W = $clog2(DIM);
  localparam int ROW_W  = $clog2(DIM) + 1;
  localparam int CYC_W  = $clog2(SC);

  loader_state_t               r_state;
  loader_state_t               w_state_nxt;
  logic [ROW_W-1:0]            r_row_cnt;
  logic [CYC_W-1:0]            r_cyc_cnt;
  logic                        r_en;
  logic                        r_wren;
  logic [DIM-1:0][BITS_AB-1:0] r_ain;
  logic [AROW_W-1:0]           r_arow;

  logic w_hs;
  logic w_load_last;
  logic w_stream_last;

  assign w_hs          = in_valid & in_ready;
  assign w_load_last   = w_hs && (r_row_cnt == ROW_W'(DIM - 1));
  // r_en is low in the first STREAM cycle, which carries the last row's WrEn.
  assign w_stream_last = r_en && (r_cyc_cnt == CYC_W'(SC - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start && !abort) w_state_nxt = LOAD;
      LOAD:    if (abort) w_state_nxt = IDLE;
               else if (w_load_last) w_state_nxt = STREAM;
      STREAM:  if (abort || w_stream_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_row_cnt <= '0;
      r_cyc_cnt <= '0;
      r_en      <= 1'b0;
      r_wren    <= 1'b0;
      r_ain     <= '0;
      r_arow    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wren  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_row_cnt <= '0;
          r_cyc_cnt <= '0;
          r_en      <= 1'b0;
        end
        LOAD: begin
          if (abort) begin
            r_row_cnt <= '0;
          end else if (w_hs) begin
            r_ain     <= in_row;
            r_arow    <= r_row_cnt[AROW_W-1:0];
            r_wren    <= 1'b1;
            r_row_cnt <= r_row_cnt + 1'b1;
          end
        end
        STREAM: begin
          if (abort || w_stream_last) begin
            r_en      <= 1'b0;
            r_cyc_cnt <= '0;
            r_row_cnt <= '0;
          end else if (!r_en) begin
            r_en <= 1'b1;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
          end
        end
        default: begin
          r_en <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (r_state == LOAD);
  assign busy     = (r_state != IDLE);
  assign en       = r_en;
  assign done     = w_stream_last && !abort;
  assign WrEn     = r_wren;
  assign Ain      = r_ain;
  assign Arow     = r_arow;

endmodule
